// File: rtl/lock_code_sender.sv
// Drives the keypad lock's buttons and code bus through a check or set-password sequence.
// Start edge to first press is 1 cycle; start edges are ignored while busy and lock waits are bounded by TIMEOUT.
module lock_code_sender #(
  parameter int PULSE_W  = 4,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 255,
  parameter int MAX_FAIL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic [6:0] code_i,
  input  logic [2:0] lock_state_i,
  output logic       chk_btn_o,
  output logic       set_btn_o,
  output logic [6:0] code_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o,
  output logic [2:0] fail_cnt_o,
  output logic       locked_out_o
);

  localparam logic [15:0] PW_L  = 16'(PULSE_W);
  localparam logic [15:0] PW_M1 = 16'(PULSE_W - 1);
  localparam logic [15:0] ST_M1 = 16'(SETTLE - 1);
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
  localparam logic [2:0]  MF_L  = 3'(MAX_FAIL);

  localparam logic [2:0] LK_IDLE   = 3'b000;
  localparam logic [2:0] LK_SET_AW = 3'b001;
  localparam logic [2:0] LK_OPENED = 3'b010;
  localparam logic [2:0] LK_ALARM  = 3'b011;
  localparam logic [2:0] LK_INPUT  = 3'b100;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_OK    = 2'b01;
  localparam logic [1:0] RES_ALARM = 2'b10;
  localparam logic [1:0] RES_ERR   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRESS1,
    ST_WAIT_ARM,
    ST_SETTLE,
    ST_PRESS2,
    ST_WAIT_RES,
    ST_PRESS_CLR,
    ST_WAIT_IDLE,
    ST_DONE
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        start_q;
  logic        mode_q;
  logic [1:0]  res_q;

  logic        start_edge;
  logic        precond_bad;
  logic        to_hit;
  logic [2:0]  arm_tgt;
  logic [2:0]  fail_inc;
  logic        fin;
  logic [1:0]  fin_res;

  assign start_edge  = start_i & ~start_q;
  assign precond_bad = locked_out_o |
                       (mode_i ? (lock_state_i != LK_OPENED) : (lock_state_i != LK_IDLE));
  assign to_hit      = (cnt == TO_M1);
  assign arm_tgt     = mode_q ? LK_SET_AW : LK_INPUT;
  assign fail_inc    = (fail_cnt_o == 3'd7) ? 3'd7 : fail_cnt_o + 3'd1;

  // Completion decision; a target state is tested before the timeout so it wins a tie.
  always_comb begin
    fin     = 1'b0;
    fin_res = RES_ERR;
    case (state)
      ST_IDLE: begin
        if (start_edge && precond_bad) fin = 1'b1;
      end
      ST_WAIT_ARM: begin
        if (lock_state_i != arm_tgt && to_hit) fin = 1'b1;
      end
      ST_WAIT_RES: begin
        if (mode_q) begin
          if (lock_state_i == LK_IDLE) begin
            fin     = 1'b1;
            fin_res = RES_OK;
          end else if (to_hit) begin
            fin = 1'b1;
          end
        end else begin
          if (lock_state_i == LK_OPENED) begin
            fin     = 1'b1;
            fin_res = RES_OK;
          end else if (lock_state_i != LK_ALARM && to_hit) begin
            fin = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (lock_state_i == LK_IDLE) begin
          fin     = 1'b1;
          fin_res = res_q;
        end else if (to_hit) begin
          fin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      start_q      <= 1'b0;
      mode_q       <= 1'b0;
      res_q        <= RES_NONE;
      chk_btn_o    <= 1'b1;
      set_btn_o    <= 1'b1;
      code_o       <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      result_o     <= RES_NONE;
      fail_cnt_o   <= '0;
      locked_out_o <= 1'b0;
    end else begin
      start_q <= start_i;
      done_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            code_o <= code_i;
            mode_q <= mode_i;
            busy_o <= 1'b1;
            cnt    <= '0;
            if (!precond_bad) begin
              state     <= ST_PRESS1;
              chk_btn_o <= mode_i;
              set_btn_o <= ~mode_i;
            end
          end
        end
        // Button released after PULSE_W cycles, then one high cycle before leaving.
        ST_PRESS1, ST_PRESS2, ST_PRESS_CLR: begin
          if (cnt == PW_M1) begin
            chk_btn_o <= 1'b1;
            set_btn_o <= 1'b1;
          end
          if (cnt == PW_L) begin
            cnt   <= '0;
            state <= (state == ST_PRESS1) ? ST_WAIT_ARM :
                     (state == ST_PRESS2) ? ST_WAIT_RES : ST_WAIT_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT_ARM: begin
          if (lock_state_i == arm_tgt) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == ST_M1) begin
            state     <= ST_PRESS2;
            cnt       <= '0;
            chk_btn_o <= mode_q;
            set_btn_o <= ~mode_q;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT_RES: begin
          if (!mode_q && lock_state_i == LK_ALARM) begin
            state     <= ST_PRESS_CLR;
            cnt       <= '0;
            res_q     <= RES_ALARM;
            chk_btn_o <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT_IDLE: cnt <= cnt + 16'd1;
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (fin) begin
        state    <= ST_DONE;
        done_o   <= 1'b1;
        result_o <= fin_res;
        if (fin_res == RES_ALARM) begin
          fail_cnt_o <= fail_inc;
          if (fail_inc >= MF_L) locked_out_o <= 1'b1;
        end else if (fin_res == RES_OK && !mode_q) begin
          fail_cnt_o <= '0;
        end
      end
    end
  end

endmodule
